// File: rtl/pow2_lut_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pow2_lut_pkg
// Brief    : Elaboration-time math for 2^x fraction tables (full and delta).
// Revision : 1.0
// ============================================================================
package pow2_lut_pkg;

    localparam int          FRAC_BITS = 60;
    // ln(2) in Q0.60, rounded to nearest
    localparam logic [63:0] LN2_Q60   = 64'h0B17217F7D1CF79B;

    // 2^(idx / 2^in_w) in Q60 via the exp() Taylor series of idx*ln2/2^in_w;
    // the argument stays below ln2, so 31 terms are far past 60-bit accuracy.
    function automatic logic [127:0] pow2_scaled(input int in_w, input int idx);
        logic [127:0] t;
        logic [127:0] term;
        logic [127:0] sum;
        t    = (128'(idx) * 128'(LN2_Q60)) >> in_w;
        term = 128'(1) << FRAC_BITS;
        sum  = term;
        for (int k = 1; k < 32; k++) begin
            term = ((term * t) >> FRAC_BITS) / 128'(k);
            sum  = sum + term;
        end
        return sum;
    endfunction

    // F(i): fractional bits of 2^x at out_w bits, ties up, saturated
    function automatic int f_value(input int in_w, input int out_w, input int idx);
        logic [127:0] y;
        logic [127:0] one;
        one = 128'(1) << out_w;
        y   = (pow2_scaled(in_w, idx) << out_w) + (128'(1) << (FRAC_BITS - 1));
        y   = (y >> FRAC_BITS) - one;
        if (y > one - 128'(1)) begin
            y = one - 128'(1);
        end
        return int'(y[31:0]);
    endfunction

    function automatic int base_value(input int in_w, input int out_w, input int lo,
                                      input int hi);
        return f_value(in_w, out_w, hi << lo);
    endfunction

    function automatic int delta_value(input int in_w, input int out_w, input int lo,
                                       input int idx);
        return f_value(in_w, out_w, idx) - f_value(in_w, out_w, (idx >> lo) << lo);
    endfunction

    // F is monotonic, so each block's largest delta sits at its last entry.
    function automatic int delta_width(input int in_w, input int out_w, input int lo);
        int max_d;
        int d;
        int w;
        max_d = 0;
        for (int j = 0; j < (1 << (in_w - lo)); j++) begin
            d = delta_value(in_w, out_w, lo, (j << lo) | ((1 << lo) - 1));
            if (d > max_d) begin
                max_d = d;
            end
        end
        w = 1;
        while ((1 << w) <= max_d) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pow2_lut.sv
`default_nettype none
// ============================================================================
// Module   : pow2_lut
// Brief    : Plain full-table registered 2^x fraction lookup (reference form).
// Revision : 1.0
// ============================================================================
module pow2_lut
    import pow2_lut_pkg::*;
#(
    parameter int IN  = 4,
    parameter int OUT = 5
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    input  logic [IN-1:0]  in,
    output logic           out_valid,
    output logic [OUT-1:0] out
);

    localparam int NI = 2 ** IN;

    logic [OUT-1:0] tab [NI];

    for (genvar g = 0; g < NI; g++) begin : g_tab
        assign tab[g] = OUT'(f_value(IN, OUT, g));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out       <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= tab[in];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pow2_lut_core.sv
`default_nettype none
// ============================================================================
// Module   : pow2_lut_core
// Brief    : Combinational delta-encoded 2^x lookup: base[hi] + delta[idx].
// Revision : 1.0
// ============================================================================
module pow2_lut_core
    import pow2_lut_pkg::*;
#(
    parameter int IN  = 4,
    parameter int OUT = 5,
    parameter int LO  = IN / 2
) (
    input  logic [IN-1:0]  idx,
    output logic [OUT-1:0] value
);

    localparam int DW = delta_width(IN, OUT, LO);
    localparam int NB = 2 ** (IN - LO);
    localparam int NI = 2 ** IN;

    logic [OUT-1:0] base_tab  [NB];
    logic [DW-1:0]  delta_tab [NI];

    for (genvar g = 0; g < NB; g++) begin : g_base
        assign base_tab[g] = OUT'(base_value(IN, OUT, LO, g));
    end

    for (genvar g = 0; g < NI; g++) begin : g_delta
        assign delta_tab[g] = DW'(delta_value(IN, OUT, LO, g));
    end

    // Sum equals F(idx) exactly, which is below 2^OUT, so no carry is lost.
    assign value = base_tab[idx[IN-1:LO]] + OUT'(delta_tab[idx]);

endmodule
`default_nettype wire

// File: rtl/pow2_delta_lut.sv
`default_nettype none
// ============================================================================
// Module   : pow2_delta_lut
// Brief    : Registered 2^x fraction lookup built on a delta-encoded table.
// Revision : 1.0
// ============================================================================
module pow2_delta_lut #(
    parameter int IN  = 4,
    parameter int OUT = 5,
    parameter int LO  = IN / 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    input  logic [IN-1:0]  in,
    output logic           out_valid,
    output logic [OUT-1:0] out
);

    logic [OUT-1:0] lut_value;

    pow2_lut_core #(
        .IN  (IN),
        .OUT (OUT),
        .LO  (LO)
    ) u_core (
        .idx   (in),
        .value (lut_value)
    );

    // out holds its last result across invalid cycles
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out       <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= lut_value;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pow2_delta_lut.sv
`default_nettype none
// ============================================================================
// Module   : tb_pow2_delta_lut
// Brief    : Scoreboard bench for pow2_delta_lut at (4,5), (4,8) and (10,11).
// Revision : 1.0
// ============================================================================
module tb_pow2_delta_lut;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  in4;
    logic [9:0]  in10;

    logic        ov45, ov48, ov10, rv45, rv48, rv10;
    logic [4:0]  o45, r45;
    logic [7:0]  o48, r48;
    logic [10:0] o10, r10;

    int checks   = 0;
    int failures = 0;
    int q45[$];
    int q48[$];
    int q10[$];
    int hold45, hold48, hold10;

    always #5 clock = ~clock;

    pow2_delta_lut #(.IN(4), .OUT(5)) d45 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in(in4),
        .out_valid(ov45), .out(o45));
    pow2_delta_lut #(.IN(4), .OUT(8)) d48 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in(in4),
        .out_valid(ov48), .out(o48));
    pow2_delta_lut #(.IN(10), .OUT(11)) d10 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in(in10),
        .out_valid(ov10), .out(o10));

    pow2_lut #(.IN(4), .OUT(5)) p45 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in(in4),
        .out_valid(rv45), .out(r45));
    pow2_lut #(.IN(4), .OUT(8)) p48 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in(in4),
        .out_valid(rv48), .out(r48));
    pow2_lut #(.IN(10), .OUT(11)) p10 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in(in10),
        .out_valid(rv10), .out(r10));

    function automatic int model_f(input int in_w, input int out_w, input int i);
        real y;
        int  r;
        y = (2.0 ** out_w) * (2.0 ** (real'(i) / (2.0 ** in_w)));
        r = int'($floor(y + 0.5)) - (1 << out_w);
        if (r > (1 << out_w) - 1) begin
            r = (1 << out_w) - 1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, queue the model result, then score all outputs after the edge.
    task automatic drive(input logic v, input int a4, input int a10);
        logic take;
        int   e;
        in_valid = v;
        in4      = 4'(a4);
        in10     = 10'(a10);
        take     = v && !reset;
        if (take) begin
            q45.push_back(model_f(4, 5, a4));
            q48.push_back(model_f(4, 8, a4));
            q10.push_back(model_f(10, 11, a10));
        end
        @(posedge clock);
        #1;
        chk("valid45", 32'(ov45), 32'(take));
        chk("valid48", 32'(ov48), 32'(take));
        chk("valid10", 32'(ov10), 32'(take));
        chk("ref_valid", 32'({rv45, rv48, rv10}), 32'({3{take}}));
        if (take) begin
            e = q45.pop_front(); hold45 = e;
            e = q48.pop_front(); hold48 = e;
            e = q10.pop_front(); hold10 = e;
        end else if (reset) begin
            hold45 = 0;
            hold48 = 0;
            hold10 = 0;
        end
        chk("out45", 32'(o45), 32'(hold45));
        chk("out48", 32'(o48), 32'(hold48));
        chk("out10", 32'(o10), 32'(hold10));
        chk("ref45", 32'(o45), 32'(r45));
        chk("ref48", 32'(o48), 32'(r48));
        chk("ref10", 32'(o10), 32'(r10));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in4      = '0;
        in10     = '0;
        hold45   = 0;
        hold48   = 0;
        hold10   = 0;

        // transactions coincident with reset are dropped
        drive(1'b1, 8, 512);
        chk("rst_out45", 32'(o45), 32'd0);
        chk("rst_valid45", 32'(ov45), 32'd0);
        drive(1'b1, 8, 512);
        reset = 1'b0;
        drive(1'b1, 8, 512);
        chk("post_rst_i8_45", 32'(o45), 32'd13);

        drive(1'b1, 0, 0);
        chk("spot_i0_45", 32'(o45), 32'd0);
        chk("spot_i0_10", 32'(o10), 32'd0);
        drive(1'b1, 4, 1);
        chk("spot_i4_45", 32'(o45), 32'd6);
        drive(1'b1, 8, 512);
        chk("spot_i8_45", 32'(o45), 32'd13);
        chk("spot_i8_48", 32'(o48), 32'd106);
        chk("spot_i512_10", 32'(o10), 32'd848);
        drive(1'b1, 15, 1023);
        chk("spot_i15_45", 32'(o45), 32'd29);
        chk("spot_i15_48", 32'(o48), 32'd234);
        chk("spot_i1023_10", 32'(o10), 32'd2045);

        drive(1'b0, 2, 5);
        chk("gap_hold45", 32'(o45), 32'd29);
        chk("gap_hold10", 32'(o10), 32'd2045);

        for (int i = 0; i < 1024; i++) begin
            drive(1'b1, i % 16, i);
        end

        for (int k = 0; k < 48; k++) begin
            drive((k % 3) != 1, (k * 7) % 16, (k * 97) % 1024);
        end
        for (int k = 0; k < 16; k++) begin
            drive(1'(($urandom_range(0, 1))), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 1023)));
        end

        // reset mid-stream clears out, which then holds through an idle cycle
        reset = 1'b1;
        drive(1'b1, 3, 3);
        reset = 1'b0;
        drive(1'b0, 9, 9);
        chk("rst_hold45", 32'(o45), 32'd0);
        drive(1'b1, 8, 512);
        chk("rerun_i8_45", 32'(o45), 32'd13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pow2_delta_lut.md
POW2_DELTA_LUT -- requirements
Module: pow2_delta_lut

Interface
REQ-001 The parameter IN SHALL default to 4 and give the input fraction width in bits; legal range 2..12.
REQ-002 The parameter OUT SHALL default to 5 and give the output fraction width in bits; legal range IN..16.
REQ-003 The parameter LO SHALL default to IN/2 and give the low-index bits used for delta lookup; legal range 1..IN-1.
REQ-004 Port list: clock  input  1  single clock; all state updates on its rising edge.
REQ-005 Port list: reset  input  1  synchronous, active-high reset.
REQ-006 Port list: in_valid  input  1  qualifies in.
REQ-007 Port list: in  input  IN  unsigned fraction x = in/2^IN, range [0,1).
REQ-008 Port list: out_valid  output  1  qualifies out.
REQ-009 Port list: out  output  OUT  fractional bits of 2^x.

Function
REQ-010 Reference value: F(i) = round-to-nearest(2^(i/2^IN) * 2^OUT) - 2^OUT, with ties rounding up, saturated to 2^OUT-1.
REQ-011 For every i in [0, 2^IN-1], out SHALL equal F(i) bit-exactly, identical to a plain full-table pow2_lut of the same IN/OUT.
REQ-012 Storage SHALL be delta-encoded: base table of 2^(IN-LO) entries holding F(hi<<LO), plus delta table of 2^IN entries holding F(i)-base[i>>LO].
REQ-013 The delta width SHALL be the minimum unsigned width covering max delta, computed at elaboration.
REQ-014 Reconstruction SHALL be out = base[in[IN-1:LO]] + delta[in] with OUT-bit result and no overflow for all legal parameters.
REQ-015 Both tables SHALL be generated at elaboration from parameters, with no external memory initialization files.
REQ-016 Latency SHALL be exactly 1 cycle: in/in_valid sampled at edge N appear on out/out_valid after edge N.
REQ-017 out_valid SHALL equal in_valid delayed one cycle.
REQ-018 out SHALL update only when in_valid=1 and hold its last value otherwise.
REQ-019 The module SHALL accept a new input every cycle with no backpressure.
REQ-020 F is monotonic non-decreasing in i; the implementation SHALL preserve this.
REQ-021 Boundary: i=0 SHALL give out=0; i=2^IN-1 SHALL give the largest value, which never saturates for legal parameters.

Reset
REQ-022 While reset=1 at a clock edge, out_valid SHALL be 0 and out SHALL be 0 after that edge.
REQ-023 A transaction presented in the same cycle as reset SHALL be discarded.
REQ-024 The first valid result after reset deasserts SHALL appear one cycle after the first in_valid=1.

Structure
REQ-025 A shared package pow2_lut_pkg SHALL hold the elaboration functions for F(i), base and delta values, and the delta-width computation, so pow2_lut and pow2_delta_lut share one definition.
REQ-026 One combinational sub-module pow2_lut_core (delta lookup plus add) SHALL be instantiated, wrapped by the output register stage.

Verification
REQ-027 Exhaustive: for each of (IN,OUT) = (4,5), (4,8) and (10,11), sweep i over 0..2^IN-1 with in_valid=1. Compare out against pow2_lut one cycle later; any mismatch is a failure.
REQ-028 Spot values at IN=4, OUT=5: i=0 -> 0; i=4 -> 6; i=8 -> 13; i=15 -> 29.
REQ-029 Spot values at IN=4, OUT=8: i=8 -> 106; i=15 -> 234.
REQ-030 Spot values at IN=10, OUT=11: i=512 -> 848; i=1023 -> 2045.
REQ-031 Reset test: assert reset with in_valid=1 and in=8. The next cycle SHALL show out_valid=0 and out=0. After deassert, in_valid=1 and in=8 SHALL give out=13 (IN=4, OUT=5) one cycle later.
REQ-032 Valid gaps: toggle in_valid while varying in. out_valid SHALL track in_valid with 1-cycle lag, and out SHALL hold during gaps.
